// File: rtl/alu_op_sequencer.sv
// Command sequencer for the shift-add ALU: takes one op per handshake, replays it
// onto the ALU bus protocol, waits for finish (or times out) and returns the result.
module alu_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_opa,
    input  logic [7:0]  req_opb,
    output logic        alu_rst,
    output logic        alu_start,
    output logic [1:0]  alu_sel,
    output logic [15:0] alu_inbus,
    input  logic [15:0] alu_outbus,
    input  logic        alu_finish,
    input  logic        alu_of,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_op,
    output logic        rsp_of,
    output logic        rsp_timeout,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_LOAD1, S_GAP, S_LOAD2, S_WAIT, S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]  op_reg, op_next;
    logic [15:0] opa_reg, opa_next;
    logic [7:0]  opb_reg, opb_next;
    logic [15:0] rsp_data_reg, rsp_data_next;
    logic        rsp_of_reg, rsp_of_next;
    logic        rsp_timeout_reg, rsp_timeout_next;
    // Keeps the ALU in reset for the cycle following a sequencer reset.
    logic        rst_pend_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            op_reg          <= '0;
            opa_reg         <= '0;
            opb_reg         <= '0;
            rsp_data_reg    <= '0;
            rsp_of_reg      <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            rst_pend_reg    <= 1'b1;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            op_reg          <= op_next;
            opa_reg         <= opa_next;
            opb_reg         <= opb_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_of_reg      <= rsp_of_next;
            rsp_timeout_reg <= rsp_timeout_next;
            rst_pend_reg    <= 1'b0;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        op_next          = op_reg;
        opa_next         = opa_reg;
        opb_next         = opb_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_of_next      = rsp_of_reg;
        rsp_timeout_next = rsp_timeout_reg;
        req_ready        = 1'b0;
        alu_start        = 1'b0;
        alu_inbus        = 16'h0000;
        rsp_valid        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_next    = req_op;
                    opa_next   = req_opa;
                    opb_next   = req_opb;
                    state_next = S_CLR;
                end
            end
            S_CLR: state_next = S_LOAD1;
            S_LOAD1: begin
                alu_start  = 1'b1;
                alu_inbus  = opa_reg;
                state_next = S_GAP;
            end
            S_GAP: begin
                alu_inbus  = opa_reg;
                state_next = S_LOAD2;
            end
            S_LOAD2: begin
                alu_inbus  = {8'h00, opb_reg};
                cnt_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                alu_inbus = {8'h00, opb_reg};
                // Finish is tested first so it wins over a coincident timeout.
                if (alu_finish) begin
                    rsp_data_next    = alu_outbus;
                    rsp_of_next      = alu_of;
                    rsp_timeout_next = 1'b0;
                    state_next       = S_RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    rsp_data_next    = 16'h0000;
                    rsp_of_next      = 1'b0;
                    rsp_timeout_next = 1'b1;
                    state_next       = S_RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign alu_rst     = rst_pend_reg | (state_reg == S_CLR);
    assign alu_sel     = op_reg;
    assign busy        = (state_reg != S_IDLE);
    assign rsp_data    = rsp_data_reg;
    assign rsp_op      = op_reg;
    assign rsp_of      = rsp_of_reg;
    assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a small ALU model answers the bus protocol,
// and expected responses are hand-computed constants.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_opa;
    logic [7:0]  req_opb;
    logic        alu_rst;
    logic        alu_start;
    logic [1:0]  alu_sel;
    logic [15:0] alu_inbus;
    logic [15:0] alu_outbus;
    logic        alu_finish;
    logic        alu_of;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_op;
    logic        rsp_of;
    logic        rsp_timeout;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // ALU model state captured from the bus
    logic [1:0] mdl_sel;
    logic [7:0] mdl_a;
    logic [7:0] mdl_m;

    always #5 clk = ~clk;

    alu_op_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_opa(req_opa), .req_opb(req_opb),
        .alu_rst(alu_rst), .alu_start(alu_start), .alu_sel(alu_sel),
        .alu_inbus(alu_inbus), .alu_outbus(alu_outbus), .alu_finish(alu_finish),
        .alu_of(alu_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_op(rsp_op), .rsp_of(rsp_of), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // 8-bit signed add/sub with overflow, signed 8x8 multiply
    task automatic alu_model(output logic [15:0] r, output logic of);
        logic [7:0] s;
        r  = 16'h0000;
        of = 1'b0;
        case (mdl_sel)
            2'b00: begin
                s  = mdl_a + mdl_m;
                r  = {8'h00, s};
                of = (mdl_a[7] == mdl_m[7]) && (s[7] != mdl_a[7]);
            end
            2'b01: begin
                s  = mdl_a - mdl_m;
                r  = {8'h00, s};
                of = (mdl_a[7] != mdl_m[7]) && (s[7] != mdl_a[7]);
            end
            2'b10: r = 16'($signed(mdl_a) * $signed(mdl_m));
            default: r = 16'h0000;
        endcase
    endtask

    // Issue a request and follow it through CLR/LOAD1/GAP/LOAD2 to the first WAIT cycle.
    task automatic issue(input logic [1:0] op, input logic [15:0] opa, input logic [7:0] opb);
        req_valid = 1'b1;
        req_op    = op;
        req_opa   = opa;
        req_opb   = opb;
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_opa   = 16'($urandom);
        req_opb   = 8'($urandom);
        chk("clr_alu_rst", 32'(alu_rst), 32'd1);
        chk("clr_req_ready", 32'(req_ready), 32'd0);
        chk("clr_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("load1_start", 32'(alu_start), 32'd1);
        chk("load1_inbus", 32'(alu_inbus), 32'(opa));
        chk("load1_sel", 32'(alu_sel), 32'(op));
        chk("load1_alu_rst", 32'(alu_rst), 32'd0);
        mdl_sel = alu_sel;
        mdl_a   = alu_inbus[7:0];
        @(negedge clk);
        chk("gap_start", 32'(alu_start), 32'd0);
        chk("gap_inbus", 32'(alu_inbus), 32'(opa));
        @(negedge clk);
        chk("load2_inbus", 32'(alu_inbus), 32'({8'h00, opb}));
        mdl_m = alu_inbus[7:0];
        @(negedge clk);
        chk("wait_inbus", 32'(alu_inbus), 32'({8'h00, opb}));
        chk("wait_sel", 32'(alu_sel), 32'(op));
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    // From the first WAIT cycle, raise finish after lat cycles with the model result.
    task automatic finish_after(input int lat);
        logic [15:0] r;
        logic        of;
        repeat (lat) @(negedge clk);
        alu_model(r, of);
        alu_finish = 1'b1;
        alu_outbus = r;
        alu_of     = of;
        @(negedge clk);
        // Junk on the ALU bus while in RESP must not disturb the response.
        alu_finish = 1'b1;
        alu_outbus = 16'hDEAD;
        alu_of     = ~of;
    endtask

    task automatic check_rsp(input string tag, input logic [15:0] exp_data, input logic exp_of,
                             input logic exp_to, input logic [1:0] exp_op, input int hold);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp_data));
        chk({tag, "_rsp_of"}, 32'(rsp_of), 32'(exp_of));
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(exp_to));
        chk({tag, "_rsp_op"}, 32'(rsp_op), 32'(exp_op));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(rsp_data), 32'(exp_data));
            chk({tag, "_hold_of"}, 32'(rsp_of), 32'(exp_of));
            chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        alu_finish = 1'b0;
        alu_outbus = 16'h0000;
        alu_of     = 1'b0;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_done_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        $display("txn %s data=%0h of=%0b timeout=%0b", tag, exp_data, exp_of, exp_to);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_opa    = 16'h0000;
        req_opb    = 8'h00;
        alu_outbus = 16'h0000;
        alu_finish = 1'b0;
        alu_of     = 1'b0;
        rsp_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_alu_rst", 32'(alu_rst), 32'd1);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_inbus", 32'(alu_inbus), 32'd0);
        chk("reset_sel", 32'(alu_sel), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        chk("post_reset_alu_rst", 32'(alu_rst), 32'd0);

        issue(2'b00, 16'd20, 8'd75);
        finish_after(3);
        check_rsp("add_20_75", 16'd95, 1'b0, 1'b0, 2'b00, 0);

        issue(2'b00, 16'h007F, 8'h7E);
        finish_after(1);
        check_rsp("add_ovf", 16'h00FD, 1'b1, 1'b0, 2'b00, 0);

        issue(2'b10, 16'd40, 8'd12);
        finish_after(5);
        check_rsp("mul_40_12", 16'd480, 1'b0, 1'b0, 2'b10, 0);

        issue(2'b10, 16'h00E7, 8'hD6);
        finish_after(0);
        check_rsp("mul_neg", 16'd1050, 1'b0, 1'b0, 2'b10, 0);

        issue(2'b01, 16'h0080, 8'h01);
        finish_after(2);
        check_rsp("sub_ovf_bp", 16'h007F, 1'b1, 1'b0, 2'b01, 10);

        // Finish on the last counted WAIT cycle must beat the timeout.
        issue(2'b01, 16'd5, 8'd10);
        finish_after(7);
        check_rsp("sub_coincide", 16'h00FB, 1'b0, 1'b0, 2'b01, 0);

        issue(2'b00, 16'd1, 8'd2);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (rsp_valid) break;
        end
        chk("timeout_latency", 32'(k), 32'd8);
        check_rsp("timeout", 16'h0000, 1'b0, 1'b1, 2'b00, 0);

        issue(2'b11, 16'd11542, 8'd135);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_alu_rst", 32'(alu_rst), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_release_alu_rst", 32'(alu_rst), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        $display("txn midrst div aborted");

        issue(2'b00, 16'd20, 8'd75);
        finish_after(4);
        check_rsp("add_after_rst", 16'd95, 1'b0, 1'b0, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream command stage for the shift-add ALU.
- Accepts one complete operation per valid/ready handshake: opcode, 16-bit first operand, 8-bit second operand.
- Replays the operation into the ALU's multi-cycle bus protocol (ALU reset pulse, start, staggered operands on inbus), then waits for finish.
- Captures the result and overflow flag and returns them on a valid/ready response port.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before abandoning the op; must be >= 2
CNT_W, 7, width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept a request
req_op  input  2  00 add, 01 sub, 10 mul, 11 div
req_opa  input  16  first operand (A for add/sub, Q for mul in [7:0], A.Q dividend for div)
req_opb  input  8  second operand (M)
alu_rst  output  1  reset to ALU, active-high
alu_start  output  1  ALU start strobe
alu_sel  output  2  ALU operation select
alu_inbus  output  16  ALU input bus
alu_outbus  input  16  ALU result bus
alu_finish  input  1  ALU done
alu_of  input  1  ALU overflow flag
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  16  captured alu_outbus
rsp_op  output  2  opcode of this response
rsp_of  output  1  captured alu_of
rsp_timeout  output  1  op abandoned, finish never seen
busy  output  1  high in every state except IDLE

Behaviour:
- States: IDLE, CLR, LOAD1, GAP, LOAD2, WAIT, RESP. One state per cycle except WAIT and RESP.
- Reset (rst=1 at edge):
  - state=IDLE, counter=0, all registered outputs 0, alu_inbus=0, alu_sel=00.
  - alu_rst=1 during the cycle after reset so the ALU is cleared with the sequencer.
  - rst overrides everything, including mid-operation and a pending response; the pending response is discarded.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid&req_ready: latch op/opa/opb into internal regs; go to CLR. Inputs are don't-care after acceptance.
- CLR: alu_rst=1, alu_start=0; next LOAD1.
- LOAD1:
  - alu_start=1, alu_sel=op, alu_inbus=opa.
  - For add/sub/mul only opa[7:0] is meaningful; the full 16 bits are still driven.
  - Next GAP.
- GAP: alu_start=0, alu_inbus holds opa, alu_sel holds op; next LOAD2.
- LOAD2 and WAIT:
  - alu_inbus={8'h00, opb}, alu_sel holds op, alu_start=0.
  - alu_inbus stays stable until RESP.
- LOAD2: clear counter; next WAIT.
- WAIT:
  - If alu_finish=1: register rsp_data=alu_outbus, rsp_of=alu_of, rsp_timeout=0; go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: rsp_data=0, rsp_of=0, rsp_timeout=1; go to RESP.
  - Otherwise counter+1.
  - If finish and the timeout limit coincide on the same cycle, finish wins.
- RESP:
  - rsp_valid=1. rsp_data/rsp_op/rsp_of/rsp_timeout are stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready: rsp_valid drops next cycle, go to IDLE.
  - alu_finish and alu_outbus are ignored in this state.
- req_ready is 0 outside IDLE. A new request is not accepted in the same cycle a response is consumed; minimum issue-to-issue spacing is 6 cycles plus ALU latency.
- of is passed through unmodified. The sequencer does no masking by op; the ALU already qualifies it.
- alu_sel is driven only from the latched op, never from req_op directly.

Test Plan:
- Add, no overflow: op=00, opa=20, opb=75 -> alu_rst high 1 cycle, alu_start high exactly 1 cycle with alu_inbus=20, inbus=75 from 2 cycles later; rsp_data[7:0]=95, rsp_of=0, rsp_timeout=0.
- Add, overflow: opa=0x7F, opb=0x7E -> rsp_data[7:0]=0xFD, rsp_of=1.
- Mul: op=10, opa=40, opb=12 -> rsp_data=480 (0x01E0), rsp_of=0. Then op=10, opa=0xE7, opb=0xD6 -> rsp_data=1050.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* fields constant, req_ready=0 throughout; releasing rsp_ready returns to IDLE with req_ready=1 the next cycle.
- Timeout: stub ALU with finish tied 0, TIMEOUT_CYCLES=8 -> rsp_valid exactly 8 cycles after entering WAIT, rsp_timeout=1, rsp_data=0.
- Reset mid-op: assert rst during WAIT of a div (op=11, opa=11542, opb=135) -> next cycle state IDLE, rsp_valid=0, alu_rst=1 for one cycle, req_ready=1 after rst deasserts; a following add 20+75 completes correctly.
